mem_req_scheduler: RTL

//  Schedules the single shared memory bus between the instruction-fetch port (p0, read-only)
//  and the load/store port (p1, read/write) of the RV32I core. Keeps one transaction in flight.

---
 rtl/mem_req_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_req_scheduler.sv
// Arbitrates the shared memory bus between fetch (p0) and load/store (p1), one transaction in flight.
// p1 has priority; a starvation counter forces a p0 win after STARVE_LIMIT consecutive losses.
module mem_req_scheduler #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  programming,
    input  logic                  system_flush,
    input  logic                  req_valid_p0,
    input  logic [ADDR_WIDTH-1:0] addr_p0,
    output logic                  grant_p0,
    output logic                  rd_valid_p0,
    output logic [DATA_WIDTH-1:0] rd_data_p0,
    input  logic                  req_valid_p1,
    input  logic [ADDR_WIDTH-1:0] addr_p1,
    input  logic                  we_p1,
    input  logic [DATA_WIDTH-1:0] wrt_data_p1,
    output logic                  grant_p1,
    output logic                  rd_valid_p1,
    output logic [DATA_WIDTH-1:0] rd_data_p1,
    output logic                  req_valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  we_o,
    output logic [DATA_WIDTH-1:0] wrt_data_o,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  data_valid,
    output logic                  timeout_err
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_P0 = 2'd1;
    localparam logic [1:0] S_BUSY_P1 = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic [7:0] to_cnt;
    logic       p0_eff, can_pick, pick_p0, pick_p1, to_hit;

    always_comb begin
        p0_eff   = req_valid_p0 & ~system_flush;
        // reset gating keeps grants low while reset is held, not just after the edge
        can_pick = (state == S_IDLE) & ~programming & ~reset;
        pick_p0  = can_pick & p0_eff & (~req_valid_p1 | (starve_cnt == 4'(STARVE_LIMIT)));
        pick_p1  = can_pick & req_valid_p1 & ~pick_p0;
        to_hit   = (to_cnt == 8'(TIMEOUT - 1));
    end

    assign grant_p0    = pick_p0;
    assign grant_p1    = pick_p1;
    assign req_valid_o = (state == S_BUSY_P0) | (state == S_BUSY_P1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            to_cnt      <= '0;
            rd_valid_p0 <= 1'b0;
            rd_valid_p1 <= 1'b0;
            rd_data_p0  <= '0;
            rd_data_p1  <= '0;
            addr_o      <= '0;
            we_o        <= 1'b0;
            wrt_data_o  <= '0;
            timeout_err <= 1'b0;
        end else begin
            rd_valid_p0 <= 1'b0;
            rd_valid_p1 <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    to_cnt <= '0;
                    if (pick_p0) begin
                        state      <= S_BUSY_P0;
                        addr_o     <= addr_p0;
                        we_o       <= 1'b0;
                        wrt_data_o <= '0;
                        starve_cnt <= '0;
                    end else if (pick_p1) begin
                        state      <= S_BUSY_P1;
                        addr_o     <= addr_p1;
                        we_o       <= we_p1;
                        wrt_data_o <= wrt_data_p1;
                        if (p0_eff && starve_cnt < 4'(STARVE_LIMIT))
                            starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                S_BUSY_P0: begin
                    if (data_valid) begin
                        // a flush landing with the response still kills it
                        if (!system_flush) begin
                            rd_valid_p0 <= 1'b1;
                            rd_data_p0  <= rd_data;
                        end
                        state  <= S_IDLE;
                        to_cnt <= '0;
                    end else if (to_hit) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        to_cnt      <= '0;
                    end else begin
                        if (system_flush) state <= S_DRAIN;
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                S_BUSY_P1: begin
                    if (data_valid) begin
                        rd_valid_p1 <= 1'b1;
                        rd_data_p1  <= we_o ? '0 : rd_data;
                        state       <= S_IDLE;
                        to_cnt      <= '0;
                    end else if (to_hit) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
                default: begin
                    // DRAIN: bus request dropped, stale fetch response swallowed
                    if (data_valid) begin
                        state  <= S_IDLE;
                        to_cnt <= '0;
                    end else if (to_hit) begin
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        to_cnt      <= '0;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule
